// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a standard-mode (one-cycle latency) sync FIFO into a
// valid/ready stream through a 2-entry skid buffer, with packet framing.
module fifo_rd_stream #(
  parameter int unsigned WIDTH     = 1024,
  parameter int unsigned PKT_LEN   = 64,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_enable,
  output logic                 o_fifo_rd_en,
  input  logic [WIDTH-1:0]     i_fifo_dout,
  input  logic                 i_fifo_empty,
  output logic                 o_m_valid,
  output logic [WIDTH-1:0]     o_m_data,
  output logic                 o_m_last,
  input  logic                 i_m_ready,
  output logic [CNT_WIDTH-1:0] o_beat_cnt,
  output logic [CNT_WIDTH-1:0] o_pkt_cnt
);

  localparam int unsigned          FILL_W    = 3;
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(PKT_LEN - 1);

  logic [WIDTH-1:0]     mem_q [2];
  logic [WIDTH-1:0]     mem_d [2];
  logic                 head_q, head_d;
  logic                 tail_q, tail_d;
  logic                 infl_q, infl_d;
  logic [1:0]           occ_q, occ_d;
  logic [CNT_WIDTH-1:0] beat_q, beat_d;
  logic [CNT_WIDTH-1:0] pkt_q, pkt_d;
  logic                 pop;
  logic [FILL_W-1:0]    fill;

  assign o_m_valid  = (occ_q != 2'd0);
  assign o_m_data   = mem_q[head_q];
  assign o_m_last   = o_m_valid & (beat_q == LAST_BEAT);
  assign o_beat_cnt = beat_q;
  assign o_pkt_cnt  = pkt_q;
  assign pop        = o_m_valid & i_m_ready;

  // Buffer occupancy after this edge; a new read is only safe if it stays below 2.
  assign fill         = FILL_W'(occ_q) + FILL_W'(infl_q) - FILL_W'(pop);
  assign o_fifo_rd_en = i_rst_n & i_enable & ~i_fifo_empty & (fill < FILL_W'(2));

  // Next-state: capture at tail, pop at head, framing counters.
  always_comb begin
    mem_d  = mem_q;
    head_d = head_q ^ pop;
    tail_d = tail_q ^ infl_q;
    infl_d = o_fifo_rd_en;
    occ_d  = fill[1:0];
    beat_d = beat_q;
    pkt_d  = pkt_q;
    if (infl_q) begin
      mem_d[tail_q] = i_fifo_dout;
    end
    if (pop) begin
      if (o_m_last) begin
        beat_d = '0;
        pkt_d  = pkt_q + CNT_WIDTH'(1);
      end else begin
        beat_d = beat_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_q  <= '{default: '0};
      head_q <= 1'b0;
      tail_q <= 1'b0;
      infl_q <= 1'b0;
      occ_q  <= 2'd0;
      beat_q <= '0;
      pkt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      infl_q <= infl_d;
      occ_q  <= occ_d;
      beat_q <= beat_d;
      pkt_q  <= pkt_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed bench with a behavioural standard-mode FIFO,
// a cycle table for streaming, and hand-written corner-case sequences.
module tb_fifo_rd_stream;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 8;

  typedef struct {
    int en, rdy, rd, valid, data, last, beat, pkt;
  } vec_t;

  typedef struct packed {
    logic [W-1:0]  data;
    logic          last;
    logic [CW-1:0] beat;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          rdy = 1'b0;
  logic          fifo_empty;
  logic [W-1:0]  fifo_dout = '0;
  logic          rd_en, m_valid, m_last;
  logic [W-1:0]  m_data;
  logic [CW-1:0] beat_cnt, pkt_cnt;
  logic          rd_en1, m_valid1, m_last1;
  logic [W-1:0]  m_data1;
  logic [CW-1:0] beat_cnt1, pkt_cnt1;

  int checks = 0;
  int errors = 0;

  fifo_rd_stream #(.WIDTH(W), .PKT_LEN(4), .CNT_WIDTH(CW)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .o_fifo_rd_en(rd_en),
    .i_fifo_dout(fifo_dout), .i_fifo_empty(fifo_empty), .o_m_valid(m_valid),
    .o_m_data(m_data), .o_m_last(m_last), .i_m_ready(rdy),
    .o_beat_cnt(beat_cnt), .o_pkt_cnt(pkt_cnt)
  );

  fifo_rd_stream #(.WIDTH(W), .PKT_LEN(1), .CNT_WIDTH(CW)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .o_fifo_rd_en(rd_en1),
    .i_fifo_dout(fifo_dout), .i_fifo_empty(fifo_empty), .o_m_valid(m_valid1),
    .o_m_data(m_data1), .o_m_last(m_last1), .i_m_ready(rdy),
    .o_beat_cnt(beat_cnt1), .o_pkt_cnt(pkt_cnt1)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: stimulus appends, the model reads one cycle after rd_en.
  logic [W-1:0] fmem [$];
  int           wr_ptr = 0;
  int           rd_ptr = 0;
  logic         rd_pending = 1'b0;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    #1;
    if (rd_pending && rst_n && (rd_ptr != wr_ptr)) begin
      fifo_dout = fmem[rd_ptr];
      rd_ptr++;
    end
  end

  // Monitor: records accepted beats and counts protocol violations.
  beat_t        got_q [$];
  int           outstanding = 0;
  int           rd_total = 0;
  int           v_rst = 0, v_credit = 0, v_ovf = 0, v_empty = 0, v_stall = 0;
  logic         prev_stall = 1'b0;
  logic         prev_last = 1'b0;
  logic [W-1:0] prev_data = '0;

  always @(negedge clk) begin
    logic pop;
    if ((rd_en && fifo_empty) || (rd_en1 && fifo_empty)) v_empty++;
    if (!rst_n) begin
      if (rd_en || m_valid || m_last || (m_data != '0) || (beat_cnt != '0) || (pkt_cnt != '0))
        v_rst++;
      outstanding = 0;
      rd_pending  = 1'b0;
      prev_stall  = 1'b0;
    end else begin
      pop = m_valid && rdy;
      if (rd_en && ((outstanding - int'(pop)) >= 2)) v_credit++;
      if (outstanding > 2) v_ovf++;
      if (prev_stall && (!m_valid || (m_data != prev_data) || (m_last != prev_last))) v_stall++;
      if (pop) got_q.push_back('{data: m_data, last: m_last, beat: beat_cnt});
      outstanding = outstanding + int'(rd_en) - int'(pop);
      if (rd_en) rd_total++;
      rd_pending = rd_en;
      prev_stall = m_valid && !rdy;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] d);
    fmem.push_back(d);
    wr_ptr++;
  endtask

  task automatic do_reset();
    en    = 1'b0;
    rdy   = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(int e, int r, int rd, int v, int d, int l, int b, int p);
    vec_t x;
    x.en = e; x.rdy = r; x.rd = rd; x.valid = v;
    x.data = d; x.last = l; x.beat = b; x.pkt = p;
    return x;
  endfunction

  vec_t vecs [11];

  initial begin
    int base;
    int k;
    int gap;
    int pushed;
    int r0;

    // 8 preloaded words, PKT_LEN 4: one cycle per row after enable rises
    vecs[0]  = mk(1, 1, 1, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 1, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 1, 1, 1, 0, 0, 0, 0);
    vecs[3]  = mk(1, 1, 1, 1, 1, 0, 1, 0);
    vecs[4]  = mk(1, 1, 1, 1, 2, 0, 2, 0);
    vecs[5]  = mk(1, 1, 1, 1, 3, 1, 3, 0);
    vecs[6]  = mk(1, 1, 1, 1, 4, 0, 0, 1);
    vecs[7]  = mk(1, 1, 1, 1, 5, 0, 1, 1);
    vecs[8]  = mk(1, 1, 0, 1, 6, 0, 2, 1);
    vecs[9]  = mk(1, 1, 0, 1, 7, 1, 3, 1);
    vecs[10] = mk(1, 1, 0, 0, 0, 0, 0, 2);

    // Reset with a word waiting, then first-word latency
    rst_n = 1'b0; en = 1'b1; rdy = 1'b1;
    push(16'hA1);
    @(negedge clk);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_last", 32'(m_last), 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_beat", 32'(beat_cnt), 0);
    chk("rst_pkt", 32'(pkt_cnt), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_rd_en", 32'(rd_en), 1);
    chk("first_valid_n0", 32'(m_valid), 0);
    @(negedge clk);
    chk("first_rd_en_empty", 32'(rd_en), 0);
    chk("first_valid_n1", 32'(m_valid), 0);
    @(negedge clk);
    chk("first_valid_n2", 32'(m_valid), 1);
    chk("first_data", 32'(m_data), 32'hA1);
    chk("first_beat", 32'(beat_cnt), 0);
    @(posedge clk); #2;

    // Streaming table
    do_reset();
    for (int i = 0; i < 8; i++) push(16'(i));
    for (int i = 0; i < 11; i++) begin
      en  = (vecs[i].en != 0);
      rdy = (vecs[i].rdy != 0);
      @(negedge clk);
      chk($sformatf("v%0d_rd_en", i), 32'(rd_en), vecs[i].rd);
      chk($sformatf("v%0d_valid", i), 32'(m_valid), vecs[i].valid);
      if (vecs[i].valid != 0) chk($sformatf("v%0d_data", i), 32'(m_data), vecs[i].data);
      chk($sformatf("v%0d_last", i), 32'(m_last), vecs[i].last);
      chk($sformatf("v%0d_beat", i), 32'(beat_cnt), vecs[i].beat);
      chk($sformatf("v%0d_pkt", i), 32'(pkt_cnt), vecs[i].pkt);
      @(posedge clk); #2;
    end

    // Backpressure with ready pattern 1,0,0,1
    do_reset();
    for (int i = 0; i < 16; i++) push(16'(i));
    base = got_q.size();
    en = 1'b1;
    for (int c = 0; (c < 200) && ((got_q.size() - base) < 16); c++) begin
      rdy = ((c % 4) == 0) || ((c % 4) == 3);
      @(posedge clk); #2;
    end
    chk("bp_count", 32'(got_q.size() - base), 16);
    for (int i = 0; (i < 16) && (base + i < got_q.size()); i++)
      chk($sformatf("bp_data%0d", i), 32'(got_q[base+i].data), 32'(i));
    chk("bp_credit", 32'(v_credit), 0);
    chk("bp_overflow", 32'(v_ovf), 0);
    chk("bp_stall_hold", 32'(v_stall), 0);

    // Enable dropped after exactly 5 reads
    do_reset();
    rdy = 1'b1;
    for (int i = 0; i < 10; i++) push(16'h20 + 16'(i));
    base = got_q.size();
    r0 = rd_total;
    en = 1'b1;
    for (int c = 0; (c < 50) && ((rd_total - r0) < 5); c++) begin
      @(posedge clk); #2;
    end
    en = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("en_off_rd_en", 32'(rd_en), 0);
    end
    chk("en_off_valid", 32'(m_valid), 0);
    chk("en_off_count", 32'(got_q.size() - base), 5);
    @(posedge clk); #2;
    en = 1'b1;
    for (int c = 0; (c < 50) && ((got_q.size() - base) < 10); c++) begin
      @(posedge clk); #2;
    end
    chk("en_on_count", 32'(got_q.size() - base), 10);
    for (int i = 0; (i < 10) && (base + i < got_q.size()); i++)
      chk($sformatf("en_data%0d", i), 32'(got_q[base+i].data), 32'h20 + 32'(i));

    // Asynchronous reset with a buffered word, a read in flight and beat 2
    do_reset();
    rdy = 1'b1;
    for (int i = 0; i < 8; i++) push(16'h30 + 16'(i));
    en = 1'b1;
    k = 0;
    for (int c = 0; (c < 30) && (k == 0); c++) begin
      @(negedge clk);
      if (m_valid && (beat_cnt == 8'd2)) k = 1;
    end
    chk("mid_reached", 32'(k), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rd_en", 32'(rd_en), 0);
    chk("mid_valid", 32'(m_valid), 0);
    chk("mid_last", 32'(m_last), 0);
    chk("mid_data", 32'(m_data), 0);
    chk("mid_beat", 32'(beat_cnt), 0);
    chk("mid_pkt", 32'(pkt_cnt), 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    base = got_q.size();
    for (int c = 0; (c < 40) && ((got_q.size() - base) < 4); c++) begin
      @(posedge clk); #2;
    end
    chk("mid_after_count", 32'(got_q.size() - base), 4);
    for (int i = 0; (i < 4) && (base + i < got_q.size()); i++) begin
      chk($sformatf("mid_after_data%0d", i), 32'(got_q[base+i].data), 32'h34 + 32'(i));
      chk($sformatf("mid_after_beat%0d", i), 32'(got_q[base+i].beat), 32'(i));
    end
    chk("mid_after_pkt", 32'(pkt_cnt), 1);

    // PKT_LEN 1: single words at random gaps
    do_reset();
    en = 1'b1;
    rdy = 1'b1;
    k = 0;
    gap = 0;
    pushed = 0;
    for (int c = 0; c < 80; c++) begin
      if (pushed < 6) begin
        if (gap == 0) begin
          push(16'h40 + 16'(pushed));
          pushed++;
          gap = int'($urandom_range(4, 0));
        end else begin
          gap--;
        end
      end
      @(negedge clk);
      if (m_valid1) begin
        chk("p1_last", 32'(m_last1), 1);
        chk("p1_beat", 32'(beat_cnt1), 0);
        chk("p1_data", 32'(m_data1), 32'h40 + 32'(k));
        k++;
      end
      @(posedge clk); #2;
    end
    chk("p1_beats", 32'(k), 6);
    chk("p1_pkt_cnt", 32'(pkt_cnt1), 6);

    // Run-wide invariants
    chk("inv_rd_when_empty", 32'(v_empty), 0);
    chk("inv_reset_outputs", 32'(v_rst), 0);
    chk("inv_credit", 32'(v_credit), 0);
    chk("inv_overflow", 32'(v_ovf), 0);
    chk("inv_stall_hold", 32'(v_stall), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
